icache_axi_refill: RTL and testbench

- AXI4 read master serving instruction-cache line refills; sits directly downstream of the instruction cache.
- Accepts a level-held refill request (cache_read_ena, cache_addr) and issues one single-beat 64-bit AXI4 read.
- Returns the data as a one-cycle cache_in_ok pulse.
- Drives axi_working_ti, which the cache uses to freeze its miss address while the refill is in flight.

---
 rtl/icache_axi_refill.sv | 114 +++++++++++
 tb/tb_icache_axi_refill.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/icache_axi_refill.sv
// Instruction-cache refill master: turns one level-held miss request into a single-beat
// 64-bit AXI4 read and hands the data back to the cache as a one-cycle cache_in_ok pulse.
module icache_axi_refill #(
    parameter int          AXI_ID_W = 4,
    parameter int unsigned AXI_ID   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cache_read_ena,
    input  logic [63:0]         cache_addr,
    output logic [63:0]         cache_or_data,
    output logic                cache_in_ok,
    output logic                cache_rd_err,
    output logic                axi_working_ti,
    output logic                axi_arvalid,
    input  logic                axi_arready,
    output logic [63:0]         axi_araddr,
    output logic [AXI_ID_W-1:0] axi_arid,
    output logic [7:0]          axi_arlen,
    output logic [2:0]          axi_arsize,
    output logic [1:0]          axi_arburst,
    input  logic                axi_rvalid,
    output logic                axi_rready,
    input  logic [63:0]         axi_rdata,
    input  logic [1:0]          axi_rresp,
    input  logic                axi_rlast,
    input  logic [AXI_ID_W-1:0] axi_rid,
    output logic [3:0]          dbg_state
);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        ADDR = 4'b0010,
        DATA = 4'b0100,
        DONE = 4'b1000
    } state_t;

    state_t state, state_next;
    logic   err_flag, err_next;
    logic   captured, cap_next;

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
    // ARVALID/ARADDR stay stable until ARREADY, RREADY is held for the whole DATA state.
    assign axi_arid    = AXI_ID_W'(AXI_ID);
    assign axi_arlen   = 8'd0;
    assign axi_arsize  = 3'b011;
    assign axi_arburst = 2'b01;
    assign dbg_state   = state;

    // The line offset and RID carry no information for a single-beat refill.
    logic unused_bits;
    assign unused_bits = ^{axi_rid, cache_addr[2:0]};

    always_comb begin
        state_next = state;
        err_next   = err_flag;
        cap_next   = captured;
        unique case (state)
            IDLE: begin
                if (cache_read_ena) begin
                    state_next = ADDR;
                    err_next   = 1'b0;
                    cap_next   = 1'b0;
                end
            end
            ADDR: begin
                if (axi_arready) state_next = DATA;
            end
            DATA: begin
                // A slave that forgets RLAST keeps us here; only the first beat's data counts,
                // but every beat's response contributes to the error flag.
                if (axi_rvalid) begin
                    cap_next = 1'b1;
                    if (axi_rresp != 2'b00) err_next = 1'b1;
                    if (axi_rlast) state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            err_flag       <= 1'b0;
            captured       <= 1'b0;
            axi_araddr     <= 64'd0;
            cache_or_data  <= 64'd0;
            axi_arvalid    <= 1'b0;
            axi_rready     <= 1'b0;
            cache_in_ok    <= 1'b0;
            cache_rd_err   <= 1'b0;
            axi_working_ti <= 1'b0;
        end else begin
            state    <= state_next;
            err_flag <= err_next;
            captured <= cap_next;
            if (state == IDLE && cache_read_ena) axi_araddr <= {cache_addr[63:3], 3'b000};
            if (state == DATA && axi_rvalid && !captured) cache_or_data <= axi_rdata;
            // Outputs are registered from the next state so they line up with the state itself.
            axi_arvalid    <= (state_next == ADDR);
            axi_rready     <= (state_next == DATA);
            cache_in_ok    <= (state_next == DONE);
            cache_rd_err   <= (state_next == DONE) && err_next;
            axi_working_ti <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_icache_axi_refill.sv
// Bench for icache_axi_refill: scripted AXI slave per transaction, expectations derived from
// the request/handshake/beat timing rules and the beat list of each transaction.
module tb_icache_axi_refill;

    logic        clk = 1'b0;
    logic        rst;
    logic        cache_read_ena;
    logic [63:0] cache_addr;
    logic [63:0] cache_or_data;
    logic        cache_in_ok;
    logic        cache_rd_err;
    logic        axi_working_ti;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [63:0] axi_araddr;
    logic [3:0]  axi_arid;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [63:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic [3:0]  axi_rid;
    logic [3:0]  dbg_state;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] bd [3];
    logic [1:0]  br [3];

    always #5 clk = ~clk;

    icache_axi_refill #(.AXI_ID_W(4), .AXI_ID(0)) dut (
        .clk(clk), .rst(rst),
        .cache_read_ena(cache_read_ena), .cache_addr(cache_addr),
        .cache_or_data(cache_or_data), .cache_in_ok(cache_in_ok),
        .cache_rd_err(cache_rd_err), .axi_working_ti(axi_working_ti),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_araddr(axi_araddr), .axi_arid(axi_arid), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rid(axi_rid),
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One refill. Cycle 0 is the request cycle; the slave accepts AR after ar_wait cycles of
    // ARVALID, then waits r_wait cycles before sending nbeats consecutive beats from bd/br.
    // cache_read_ena stays high for the first 'hold' cycles of the transaction.
    task automatic do_read(input logic [63:0] addr, input int ar_wait, input int r_wait,
                           input int nbeats, input int hold);
        logic [63:0] exp_addr;
        logic        exp_err;
        int          rs, k;
        logic        vld;
        exp_addr = addr & ~64'h7;
        exp_err  = 1'b0;
        for (int j = 0; j < nbeats; j++) exp_err |= (br[j] != 2'b00);
        rs = 2 + ar_wait + r_wait;
        k  = rs + nbeats - 1;
        for (int cy = 0; cy <= k + 2; cy++) begin
            if (cy > 0) begin
                check($sformatf("arvalid c%0d", cy), 64'(axi_arvalid), 64'(cy <= 1 + ar_wait));
                check($sformatf("rready c%0d", cy), 64'(axi_rready),
                      64'(cy >= 2 + ar_wait && cy <= k));
                check($sformatf("in_ok c%0d", cy), 64'(cache_in_ok), 64'(cy == k + 1));
                check($sformatf("rd_err c%0d", cy), 64'(cache_rd_err),
                      64'(cy == k + 1 && exp_err));
                check($sformatf("working c%0d", cy), 64'(axi_working_ti), 64'(cy <= k + 1));
                if (cy <= 1 + ar_wait) check($sformatf("araddr c%0d", cy), axi_araddr, exp_addr);
                if (cy >= k + 1) check($sformatf("or_data c%0d", cy), cache_or_data, bd[0]);
            end
            cache_read_ena = (cy < hold);
            cache_addr     = (cy == 0) ? addr : {$urandom, $urandom};
            axi_arready    = (cy == 1 + ar_wait);
            vld            = (cy >= rs && cy < rs + nbeats);
            axi_rvalid     = vld;
            axi_rdata      = vld ? bd[cy - rs] : {$urandom, $urandom};
            axi_rresp      = vld ? br[cy - rs] : 2'($urandom);
            axi_rlast      = vld ? (cy == rs + nbeats - 1) : 1'($urandom);
            axi_rid        = 4'($urandom);
            if (cy < k + 2) step();
        end
    endtask

    initial begin
        rst = 1'b0;
        cache_read_ena = 1'b0;
        cache_addr = '0;
        axi_arready = 1'b0;
        axi_rvalid = 1'b0;
        axi_rdata = '0;
        axi_rresp = '0;
        axi_rlast = 1'b0;
        axi_rid = '0;
        step();
        step();
        check("reset arvalid", 64'(axi_arvalid), 64'd0);
        check("reset rready", 64'(axi_rready), 64'd0);
        check("reset in_ok", 64'(cache_in_ok), 64'd0);
        check("reset working", 64'(axi_working_ti), 64'd0);
        check("reset or_data", cache_or_data, 64'd0);
        check("reset araddr", axi_araddr, 64'd0);
        rst = 1'b1;
        step();
        check("arlen", 64'(axi_arlen), 64'd0);
        check("arsize", 64'(axi_arsize), 64'd3);
        check("arburst", 64'(axi_arburst), 64'd1);
        check("arid", 64'(axi_arid), 64'd0);

        // Zero-wait read
        bd[0] = 64'h1122_3344_5566_7788; br[0] = 2'b00;
        do_read(64'h8000_0014, 0, 0, 1, 1);

        // AR backpressure with request dropped after two cycles of ADDR
        bd[0] = {$urandom, $urandom}; br[0] = 2'b00;
        do_read(64'h0000_1238, 5, 0, 1, 3);

        // R wait plus error, then a clean read
        bd[0] = 64'hDEAD_BEEF; br[0] = 2'b10;
        do_read(64'h4000_0100, 0, 7, 1, 1);
        bd[0] = {$urandom, $urandom}; br[0] = 2'b00;
        do_read(64'h4000_0108, 0, 0, 1, 1);

        // RLAST violation: three beats, last only on the third
        bd[0] = 64'hAAAA_0000_0000_000A; bd[1] = 64'hBBBB_0000_0000_000B;
        bd[2] = 64'hCCCC_0000_0000_000C;
        br[0] = 2'b00; br[1] = 2'b00; br[2] = 2'b00;
        do_read(64'h2000_0040, 0, 0, 3, 1);

        // Back-to-back with the request held high, including through DONE
        bd[0] = {$urandom, $urandom}; br[0] = 2'b00;
        do_read(64'h1000_0000, 0, 0, 1, 1000);
        bd[0] = {$urandom, $urandom};
        do_read(64'h1000_0ABC, 0, 0, 1, 1000);
        bd[0] = {$urandom, $urandom};
        do_read(64'h1000_1F0F, 0, 0, 1, 4);

        // Reset asserted while in DATA
        cache_addr = 64'h3000_0000; cache_read_ena = 1'b1;
        step();
        cache_read_ena = 1'b0; axi_arready = 1'b1;
        step();
        axi_arready = 1'b0;
        check("pre-reset rready", 64'(axi_rready), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("async arvalid", 64'(axi_arvalid), 64'd0);
        check("async rready", 64'(axi_rready), 64'd0);
        check("async in_ok", 64'(cache_in_ok), 64'd0);
        check("async working", 64'(axi_working_ti), 64'd0);
        step();
        rst = 1'b1;
        step();
        check("post-reset arvalid", 64'(axi_arvalid), 64'd0);
        check("post-reset working", 64'(axi_working_ti), 64'd0);
        bd[0] = {$urandom, $urandom}; br[0] = 2'b00;
        do_read(64'h3000_0018, 0, 0, 1, 1);

        // Randomized refills
        for (int t = 0; t < 24; t++) begin
            int nb;
            nb = $urandom_range(1, 3);
            for (int j = 0; j < 3; j++) begin
                bd[j] = {$urandom, $urandom};
                br[j] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end
            do_read({$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3), nb,
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
